ita_mask_gen: RTL



---
 rtl/ita_mask_gen_pkg.sv | 52 +++++
 rtl/ita_mask_gen_lane_eval.sv | 50 +++++
 rtl/ita_mask_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ita_mask_gen_pkg.sv
// Shared types and geometry for the QK attention-mask generator.
package ita_mask_gen_pkg;

    localparam int unsigned MaskN     = 16;
    localparam int unsigned MaskM     = 64;
    localparam int unsigned MaxSeqLen = 4096;
    localparam int unsigned ParamW    = 16;
    localparam int unsigned CoordW    = $clog2(MaxSeqLen);
    localparam int unsigned Beats     = MaskM * MaskM / MaskN;
    localparam int unsigned CntW      = $clog2(Beats);
    localparam int unsigned LogPW     = $clog2(ParamW);

    typedef enum logic [2:0] {
        NONE,
        CAUSAL,
        ANTI_CAUSAL,
        STRIDED,
        SLIDING,
        STRIDED_SLIDING,
        BLOCK_DIAG
    } mask_mode_e;

    typedef struct packed {
        mask_mode_e        mode;
        logic [ParamW-1:0] p;
        logic [CoordW-1:0] seq_len;
    } mask_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } mask_state_e;

    function automatic logic [LogPW-1:0] log2_p(input logic [ParamW-1:0] p);
        log2_p = '0;
        for (int i = 0; i < ParamW; i++) begin
            if (p[i]) log2_p = LogPW'(i);
        end
    endfunction

    function automatic logic cfg_illegal(input mask_cfg_t c);
        logic not_pow2;
        not_pow2 = (c.p == '0) || ((c.p & (c.p - 1'b1)) != '0);
        cfg_illegal = 1'b0;
        if (c.mode == STRIDED || c.mode == STRIDED_SLIDING || c.mode == BLOCK_DIAG)
            cfg_illegal = not_pow2;
        else if (c.mode == SLIDING)
            cfg_illegal = (c.p == '0);
    endfunction

endpackage

// File: rtl/ita_mask_gen_lane_eval.sv
// Single-lane mask decision from absolute row/col and the latched mode.
module ita_mask_lane_eval
    import ita_mask_gen_pkg::*;
(
    input  logic [CoordW:0]    row_i,
    input  logic [CoordW:0]    col_i,
    input  logic [CoordW:0]    seq_len_i,
    input  mask_mode_e         mode_i,
    input  logic [ParamW-1:0]  p_i,
    input  logic [LogPW-1:0]   log2p_i,
    output logic               mask_o
);
    // Wide enough for both the signed distance and the unsigned parameter.
    localparam int unsigned DW = ((ParamW > CoordW) ? ParamW : CoordW) + 2;

    logic signed [CoordW+1:0] d;
    logic signed [DW-1:0]     d_x;
    logic signed [DW-1:0]     p_x;
    logic signed [DW-1:0]     ad_x;
    logic [DW-1:0]            pm1;
    logic                     pad;
    logic                     strided;
    logic                     sliding;
    logic                     term;

    assign d       = $signed({1'b0, col_i}) - $signed({1'b0, row_i});
    assign d_x     = DW'(d);
    assign p_x     = $signed(DW'(p_i));
    assign ad_x    = (d_x < 0) ? -d_x : d_x;
    assign pm1     = DW'(p_i) - DW'(1);
    assign pad     = (col_i >= seq_len_i);
    assign strided = |(d_x & pm1);
    assign sliding = (ad_x >= p_x);

    always_comb begin
        term = 1'b0;
        unique case (mode_i)
            CAUSAL:          term = (d_x > p_x);
            ANTI_CAUSAL:     term = (-d_x > p_x);
            STRIDED:         term = strided;
            SLIDING:         term = sliding;
            STRIDED_SLIDING: term = strided & sliding;
            BLOCK_DIAG:      term = (row_i >> log2p_i) != (col_i >> log2p_i);
            default:         term = 1'b0;
        endcase
    end

    assign mask_o = pad | term;

endmodule

// File: rtl/ita_mask_gen.sv
// Attention-mask generator: beat counter, tile FSM and registered mask stream.
module ita_mask_gen
    import ita_mask_gen_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  mask_cfg_t         cfg_i,
    input  logic              start_i,
    input  logic [CoordW-1:0] tile_x_i,
    input  logic [CoordW-1:0] tile_y_i,
    input  logic              apply_i,
    input  logic              flush_i,
    input  logic              beat_valid_i,
    output logic              beat_ready_o,
    output logic              mask_valid_o,
    input  logic              mask_ready_i,
    output logic [MaskN-1:0]  mask_o,
    output logic              busy_o,
    output logic              tile_done_o,
    output logic              cfg_err_o
);
    localparam int unsigned LogM = $clog2(MaskM);
    localparam int unsigned LogN = $clog2(MaskN);
    localparam int unsigned RowW = CoordW + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

    mask_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    mask_cfg_t         cfg_q, cfg_d;
    logic [CoordW-1:0] tx_q, tx_d;
    logic [CoordW-1:0] ty_q, ty_d;
    logic              apply_q, apply_d;
    logic              err_q, err_d;
    logic [MaskN-1:0]  mask_q, mask_d;
    logic              vld_q, vld_d;

    logic              accept;
    logic              last_hs;
    logic [RowW-1:0]   row;
    logic [RowW-1:0]   col_base;
    logic [RowW-1:0]   seq_eff;
    logic [LogPW-1:0]  log2p;
    logic [MaskN-1:0]  lanes;

    assign beat_ready_o = (state_q == ST_RUN) & (~vld_q | mask_ready_i);
    assign accept       = beat_valid_i & beat_ready_o;
    assign last_hs      = (state_q == ST_DRAIN) & vld_q & mask_ready_i;

    // Column-major beat order: low count bits walk rows, high bits pick the lane group.
    assign row      = (RowW'(ty_q) << LogM) + RowW'(cnt_q[LogM-1:0]);
    assign col_base = (RowW'(tx_q) << LogM)
                    + (RowW'(cnt_q[CntW-1:LogM]) << LogN);
    assign seq_eff  = (cfg_q.seq_len == '0) ? RowW'(MaxSeqLen)
                                            : RowW'(cfg_q.seq_len);
    assign log2p    = log2_p(cfg_q.p);

    for (genvar i = 0; i < MaskN; i++) begin : g_lane
        ita_mask_lane_eval u_lane (
            .row_i     (row),
            .col_i     (col_base + RowW'(i)),
            .seq_len_i (seq_eff),
            .mode_i    (cfg_q.mode),
            .p_i       (cfg_q.p),
            .log2p_i   (log2p),
            .mask_o    (lanes[i])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        apply_d = apply_q;
        err_d   = err_q;
        mask_d  = mask_q;
        vld_d   = vld_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            vld_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d    = ST_RUN;
                        cnt_d      = '0;
                        err_d      = cfg_illegal(cfg_i);
                        cfg_d      = cfg_i;
                        cfg_d.mode = err_d ? NONE : cfg_i.mode;
                        tx_d       = tile_x_i;
                        ty_d       = tile_y_i;
                        apply_d    = apply_i;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (cnt_q == LastCnt) state_d = ST_DRAIN;
                        else                  cnt_d   = cnt_q + CntW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (last_hs) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (accept) begin
                mask_d = apply_q ? lanes : '0;
                vld_d  = 1'b1;
            end else if (mask_ready_i) begin
                vld_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cfg_q   <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            apply_q <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            apply_q <= apply_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            vld_q   <= vld_d;
        end
    end

    assign mask_o       = mask_q;
    assign mask_valid_o = vld_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign tile_done_o  = last_hs & ~flush_i;
    assign cfg_err_o    = err_q;

endmodule
